adc_scan_sched: RTL and testbench

Sequencer for the MCP3008 SPI transaction engine: on a programmable sample tick it scans the enabled ADC channels in ascending order, issues one conversion request per channel over a valid/ready handshake, and emits each result as a tagged sample stream toward the guitar-filter datapath. Sits between the SPI engine and the filter front end. Owns channel selection, sample-rate pacing, overrun and timeout detection.

---
 rtl/adc_pkg.sv | 39 +++
 rtl/adc_tick_gen.sv | 23 ++
 rtl/adc_scan_sched.sv | 179 +++++++++++++++++
 tb/tb_adc_scan_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, scan FSM state type and mask search helper
// for the MCP3008 scan sequencer.
package adc_pkg;

    localparam int N        = 10;
    localparam int CHANNELS = 8;
    localparam int CHAN_W   = 3;
    localparam int MAX_CH   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        STORE
    } scan_state_t;

    typedef struct packed {
        logic              found;
        logic [CHAN_W-1:0] idx;
    } bit_sel_t;

    // Lowest set bit of mask at or above index 'from'.
    function automatic bit_sel_t next_set_bit(
        input logic [MAX_CH-1:0] mask,
        input int                from
    );
        bit_sel_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                r.found = 1'b1;
                r.idx   = CHAN_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Free-running sample-period counter; tick pulses on the cycle the
// counter wraps, so a period of 0 ticks every cycle.
module adc_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             CLK50,
    input  logic             reset,
    input  logic [DIV_W-1:0] sample_period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick  = (cnt_q >= sample_period);
    assign cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adc_scan_sched.sv
// Scans enabled ADC channels on each sample tick and streams tagged samples.
// ADC_SCAN_AVG_EN: average 4 back-to-back conversions per channel.
module adc_scan_sched #(
    parameter int N        = adc_pkg::N,
    parameter int CHANNELS = adc_pkg::CHANNELS,
    parameter int CHAN_W   = adc_pkg::CHAN_W,
    parameter int DIV_W    = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic                CLK50,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic [DIV_W-1:0]    sample_period,
    output logic                req_valid,
    output logic [CHAN_W-1:0]   req_chan,
    input  logic                req_ready,
    input  logic                rsp_valid,
    input  logic [N-1:0]        rsp_data,
    output logic                sample_valid,
    output logic [CHAN_W-1:0]   sample_chan,
    output logic [N-1:0]        sample_data,
    output logic                frame_done,
    output logic                overrun,
    output logic                timeout_err
);

    import adc_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT) + 1;

    scan_state_t         state_q, state_d;
    logic                tick;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [N-1:0]        data_q, data_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                ovr_q, ovr_d;
    logic                tmo_q, tmo_d;
    bit_sel_t            first_sel;
    bit_sel_t            next_sel;
    logic                start;
    logic                accept;
    logic                expired;
    logic                last_conv;
`ifdef ADC_SCAN_AVG_EN
    logic [1:0]          rep_q, rep_d;
    logic [N+1:0]        acc_q, acc_d;
    logic [N+1:0]        acc_sum;
`endif

    adc_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick (
        .CLK50        (CLK50),
        .reset        (reset),
        .sample_period(sample_period),
        .tick         (tick)
    );

    assign first_sel = next_set_bit(MAX_CH'(chan_mask), 0);
    assign next_sel  = next_set_bit(MAX_CH'(mask_q), int'(chan_q) + 1);

    assign start   = (state_q == IDLE) && tick && enable && (|chan_mask);
    assign accept  = (state_q == ISSUE) && req_ready;
    assign expired = (state_q == WAIT_RSP) && !rsp_valid
                     && (to_q == TO_W'(TIMEOUT - 1));

`ifdef ADC_SCAN_AVG_EN
    assign acc_sum   = acc_q + (N+2)'(rsp_data);
    assign last_conv = (rep_q == 2'd3);
`else
    assign last_conv = 1'b1;
`endif

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (req_ready) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_valid)    state_d = last_conv ? STORE : ISSUE;
                else if (expired) state_d = IDLE;
            end
            STORE: begin
                state_d = next_sel.found ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid    = (state_q == ISSUE);
        req_chan     = chan_q;
        sample_valid = (state_q == STORE);
        sample_chan  = chan_q;
        sample_data  = data_q;
        frame_done   = (state_q == STORE) && !next_sel.found;
        overrun      = ovr_q;
        timeout_err  = tmo_q;
    end

    always_comb begin
        mask_d = mask_q;
        chan_d = chan_q;
        data_d = data_q;
        to_d   = to_q;
        ovr_d  = ovr_q | (tick && (state_q != IDLE));
        tmo_d  = tmo_q | expired;
`ifdef ADC_SCAN_AVG_EN
        rep_d  = rep_q;
        acc_d  = acc_q;
`endif
        if (start) begin
            mask_d = chan_mask;
            chan_d = first_sel.idx;
        end
        if (state_q == STORE && next_sel.found) begin
            chan_d = next_sel.idx;
        end
        if (accept) begin
            to_d = '0;
        end else if (state_q == WAIT_RSP) begin
            to_d = to_q + TO_W'(1);
        end
`ifdef ADC_SCAN_AVG_EN
        // Accumulator restarts whenever a new channel is selected.
        if (start || (state_q == STORE && next_sel.found)) begin
            rep_d = '0;
            acc_d = '0;
        end
        if (state_q == WAIT_RSP && rsp_valid) begin
            rep_d = rep_q + 2'd1;
            acc_d = acc_sum;
            if (last_conv) data_d = acc_sum[N+1:2];
        end
`else
        if (state_q == WAIT_RSP && rsp_valid) begin
            data_d = rsp_data;
        end
`endif
    end

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            chan_q <= '0;
            data_q <= '0;
            to_q   <= '0;
            ovr_q  <= 1'b0;
            tmo_q  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            rep_q  <= '0;
            acc_q  <= '0;
`endif
        end else begin
            mask_q <= mask_d;
            chan_q <= chan_d;
            data_q <= data_d;
            to_q   <= to_d;
            ovr_q  <= ovr_d;
            tmo_q  <= tmo_d;
`ifdef ADC_SCAN_AVG_EN
            rep_q  <= rep_d;
            acc_q  <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Bench for adc_scan_sched: frame-level reference model plus a simple
// SPI-engine responder, checked every cycle on the falling clock edge.
module tb_adc_scan_sched;

    localparam int N   = 10;
    localparam int CH  = 8;
    localparam int CW  = 3;
    localparam int DW  = 16;
    localparam int TMO = 4096;
`ifdef ADC_SCAN_AVG_EN
    localparam int REPS = 4;
`else
    localparam int REPS = 1;
`endif

    logic          CLK50 = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CH-1:0] chan_mask = '0;
    logic [DW-1:0] sample_period = '0;
    logic          req_valid;
    logic [CW-1:0] req_chan;
    logic          req_ready = 1'b0;
    logic          rsp_valid = 1'b0;
    logic [N-1:0]  rsp_data = '0;
    logic          sample_valid;
    logic [CW-1:0] sample_chan;
    logic [N-1:0]  sample_data;
    logic          frame_done;
    logic          overrun;
    logic          timeout_err;

    always #5 CLK50 = ~CLK50;

    adc_scan_sched dut (
        .CLK50        (CLK50),
        .reset        (reset),
        .enable       (enable),
        .chan_mask    (chan_mask),
        .sample_period(sample_period),
        .req_valid    (req_valid),
        .req_chan     (req_chan),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Engine behaviour knobs
    bit eng_ready;
    int eng_lat;
    bit eng_spur;
    int base [CH];

    // Reference model state: frame as a queue of channels to visit
    bit run = 0;
    int c = 0;
    bit m_active, m_wait, m_ovr, m_tmo, m_smp_last;
    int m_req_from, m_smp_cyc, m_acc_cyc, rsp_cyc, rsp_val;
    int m_cnt, m_sum, m_smp_data, m_smp_chan;
    int chans[$];

    // Observation log
    int s_cyc[$];
    int s_chan[$];
    int s_data[$];
    int s_fd[$];
    int reqcnt, ovr_first, tmo_first, last_acc;

    task automatic clear_model();
        m_active = 0; m_wait = 0; m_ovr = 0; m_tmo = 0; m_smp_last = 0;
        m_req_from = -1; m_smp_cyc = -1; m_acc_cyc = 0;
        rsp_cyc = -1; rsp_val = 0; m_cnt = 0; m_sum = 0;
        m_smp_data = 0; m_smp_chan = 0;
        chans.delete();
        s_cyc.delete(); s_chan.delete(); s_data.delete(); s_fd.delete();
        reqcnt = 0; ovr_first = -1; tmo_first = -1; last_acc = -1;
    endtask

    always @(negedge CLK50) begin
        bit tk, exp_req, exp_smp, st;
        if (run) begin
            tk = (c % (int'(sample_period) + 1)) == int'(sample_period);
            exp_req = m_active && m_req_from >= 0 && c >= m_req_from;
            exp_smp = m_active && c == m_smp_cyc;

            chk("req_valid", int'(req_valid), int'(exp_req));
            if (exp_req && chans.size() > 0)
                chk("req_chan", int'(req_chan), chans[0]);
            chk("sample_valid", int'(sample_valid), int'(exp_smp));
            if (exp_smp) begin
                chk("sample_chan", int'(sample_chan), m_smp_chan);
                chk("sample_data", int'(sample_data), m_smp_data);
            end
            chk("frame_done", int'(frame_done), int'(exp_smp && m_smp_last));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("timeout_err", int'(timeout_err), int'(m_tmo));

            if (sample_valid) begin
                s_cyc.push_back(c);
                s_chan.push_back(int'(sample_chan));
                s_data.push_back(int'(sample_data));
                s_fd.push_back(int'(frame_done));
            end
            if (req_valid) reqcnt++;
            if (overrun && ovr_first < 0) ovr_first = c;
            if (timeout_err && tmo_first < 0) tmo_first = c;

            req_ready = eng_ready;
            rsp_valid = (c == rsp_cyc) || (eng_spur && (c % 2 == 1));
            rsp_data  = (c == rsp_cyc) ? N'(rsp_val) : N'(c);

            st = !m_active && tk && enable && (chan_mask != '0);
            if (m_active && tk) m_ovr = 1;
            if (m_active) begin
                if (exp_req && req_ready) begin
                    m_req_from = -1;
                    m_wait = 1;
                    m_acc_cyc = c;
                    last_acc = c;
                    rsp_val = base[chans[0]] + m_cnt;
                    rsp_cyc = (eng_lat > 0) ? c + eng_lat : -1;
                end else if (m_wait && rsp_valid) begin
                    m_wait = 0;
                    rsp_cyc = -1;
                    m_sum += int'(rsp_data);
                    m_cnt++;
                    if (m_cnt == REPS) begin
                        m_smp_cyc = c + 1;
                        m_smp_chan = chans[0];
                        m_smp_data = m_sum / REPS;
                        m_smp_last = (chans.size() == 1);
                    end else begin
                        m_req_from = c + 1;
                    end
                end else if (m_wait && c - m_acc_cyc == TMO) begin
                    m_tmo = 1;
                    m_active = 0;
                    m_wait = 0;
                    rsp_cyc = -1;
                    chans.delete();
                end else if (exp_smp) begin
                    void'(chans.pop_front());
                    m_cnt = 0;
                    m_sum = 0;
                    m_smp_cyc = -1;
                    if (chans.size() > 0) m_req_from = c + 1;
                    else m_active = 0;
                end
            end
            if (st) begin
                chans.delete();
                for (int i = 0; i < CH; i++)
                    if (chan_mask[i]) chans.push_back(i);
                m_active = 1;
                m_req_from = c + 1;
                m_cnt = 0;
                m_sum = 0;
            end
            c++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK50);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK50);
        #1;
        run = 0;
        reset = 1'b1;
        #1;
        chk("req_drop", int'(req_valid), 0);
        clear_model();
        cycles(3);
        chk("rst_outs", int'({req_valid, req_chan, sample_valid, sample_chan,
                              sample_data, frame_done, overrun, timeout_err}), 0);
        reset = 1'b0;
        c = 0;
        run = 1;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) base[i] = 100 * i;
        eng_ready = 1; eng_lat = 5; eng_spur = 0;

        // Two-channel frames every 100 cycles
        sample_period = 16'd99; chan_mask = 8'b0000_0101; enable = 1;
        do_reset();
        cycles(360);
        chk("t1_n", s_cyc.size(), 6);
        if (s_cyc.size() >= 3) begin
            chk("t1_c0", s_chan[0], 0);
            chk("t1_c1", s_chan[1], 2);
            chk("t1_fd0", s_fd[0], 0);
            chk("t1_fd1", s_fd[1], 1);
            chk("t1_gap", s_cyc[2] - s_cyc[0], 100);
`ifdef ADC_SCAN_AVG_EN
            chk("t1_d0", s_data[0], 1);
            chk("t1_d1", s_data[1], 201);
            chk("t1_cyc", s_cyc[0], 124);
`else
            chk("t1_d0", s_data[0], 0);
            chk("t1_d1", s_data[1], 200);
            chk("t1_cyc", s_cyc[0], 106);
`endif
        end

        // Ticks with empty mask, then with enable low; stray responses
        sample_period = 16'd3; chan_mask = '0; enable = 1; eng_spur = 1;
        do_reset();
        cycles(20);
        chan_mask = 8'hFF; enable = 0;
        cycles(20);
        chk("t2_req", reqcnt, 0);
        chk("t2_smp", s_cyc.size(), 0);
        chk("t2_ovr", int'(overrun), 0);
        eng_spur = 0;

        // Ticks far faster than a full 8-channel frame
        sample_period = 16'd3; chan_mask = 8'hFF; enable = 1; eng_lat = 10;
        do_reset();
        cycles(6);
        chan_mask = 8'h01;
        cycles(400);
        chk("t3_ovr_first", ovr_first, 8);
        chk("t3_n", int'(s_cyc.size() >= 8), 1);
        if (s_cyc.size() >= 8) begin
            chk("t3_c7", s_chan[7], 7);
            chk("t3_fd6", s_fd[6], 0);
            chk("t3_fd7", s_fd[7], 1);
        end

        // Engine accepts and never answers
        sample_period = 16'd49; chan_mask = 8'b0001_0010; enable = 1; eng_lat = 0;
        do_reset();
        for (int k = 0; k < 4400 && !timeout_err; k++) cycles(1);
        chk("t4_flag", int'(timeout_err), 1);
        eng_lat = 2;
        cycles(1);
        chk("t4_dly", tmo_first - last_acc, TMO + 1);
        chk("t4_smp0", s_cyc.size(), 0);
        for (int k = 0; k < 200 && s_cyc.size() == 0; k++) cycles(1);
        chk("t4_n", int'(s_cyc.size() > 0), 1);
        if (s_cyc.size() > 0) begin
            chk("t4_c", s_chan[0], 1);
            chk("t4_d", s_data[0], (REPS == 4) ? 101 : 100);
        end

        // Engine stalls on ready; request must hold without timing out
        sample_period = 16'd199; chan_mask = 8'h80; enable = 1;
        eng_ready = 0; eng_lat = 3;
        do_reset();
        for (int k = 0; k < 300 && !req_valid; k++) cycles(1);
        cycles(50);
        chk("t5_hold", int'(reqcnt >= 50), 1);
        eng_ready = 1;
        for (int k = 0; k < 100 && s_cyc.size() == 0; k++) cycles(1);
        chk("t5_n", s_cyc.size(), 1);
        if (s_cyc.size() > 0) begin
            chk("t5_c", s_chan[0], 7);
            chk("t5_d", s_data[0], (REPS == 4) ? 701 : 700);
        end
        chk("t5_tmo", int'(timeout_err), 0);
        eng_ready = 0;
        for (int k = 0; k < 300 && !req_valid; k++) cycles(1);
        chk("t5_req2", int'(req_valid), 1);
        cycles(3);

        // Averaging run on a single channel
        sample_period = 16'd9; chan_mask = 8'h08; enable = 1;
        base[3] = 1000; eng_ready = 1; eng_lat = 1;
        do_reset();
        for (int k = 0; k < 100 && s_cyc.size() == 0; k++) cycles(1);
        cycles(1);
        chk("t6_n", int'(s_cyc.size() > 0), 1);
        if (s_cyc.size() > 0) begin
            chk("t6_c", s_chan[0], 3);
            chk("t6_d", s_data[0], (REPS == 4) ? 1001 : 1000);
            chk("t6_fd", s_fd[0], 1);
        end
        cycles(5);
        run = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
